// File: rtl/motion_scheduler.sv
// Frame-locked round-robin update scheduler: grants one object at a time
// during vertical blanking, with per-grant timeout and overrun reporting.
module motion_scheduler #(
    parameter int unsigned N          = 4,
    parameter int unsigned VBLANK_ROW = 600,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [10:0]   display_row,
    input  logic [11:0]   display_col,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  done,
    output logic [N-1:0]  grant,
    output logic          frame_pulse,
    output logic          busy,
    output logic [15:0]   frame_count,
    output logic          timeout,
    output logic          overrun
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SELECT = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    logic [1:0]    state, state_nxt;
    logic          vb_q;
    logic [N-1:0]  pending, pending_nxt;
    logic [IW-1:0] rr_ptr, rr_nxt;
    logic [IW-1:0] cur_idx, idx_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [N-1:0]  grant_nxt;
    logic [15:0]   count_nxt;
    logic          timeout_nxt;
    logic          overrun_nxt;
    logic          busy_nxt;

    logic          vb_c;
    logic          fs_c;
    logic          sel_found_c;
    logic [IW-1:0] sel_idx_c;
    logic [IW-1:0] pos_c;

    // Column is reserved; folded here so it is visibly consumed.
    logic unused_col;
    assign unused_col = ^display_col;

    assign vb_c = (display_row == 11'(VBLANK_ROW));
    assign fs_c = vb_c && !vb_q;

    // First pending object at or above rr_ptr, wrapping modulo N.
    always_comb begin
        sel_found_c = 1'b0;
        sel_idx_c   = '0;
        pos_c       = '0;
        for (int k = 0; k < N; k++) begin
            pos_c = IW'((32'(rr_ptr) + 32'(k)) % 32'(N));
            if (!sel_found_c && pending[pos_c]) begin
                sel_found_c = 1'b1;
                sel_idx_c   = pos_c;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            vb_q        <= 1'b0;
            pending     <= '0;
            rr_ptr      <= '0;
            cur_idx     <= '0;
            timer       <= '0;
            grant       <= '0;
            frame_pulse <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
            timeout     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_nxt;
            vb_q        <= vb_c;
            pending     <= pending_nxt;
            rr_ptr      <= rr_nxt;
            cur_idx     <= idx_nxt;
            timer       <= timer_nxt;
            grant       <= grant_nxt;
            frame_pulse <= fs_c;
            busy        <= busy_nxt;
            frame_count <= count_nxt;
            timeout     <= timeout_nxt;
            overrun     <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        rr_nxt      = rr_ptr;
        idx_nxt     = cur_idx;
        timer_nxt   = timer;
        grant_nxt   = grant;
        timeout_nxt = 1'b0;
        overrun_nxt = fs_c && (state != S_IDLE);
        count_nxt   = fs_c ? frame_count + 16'd1 : frame_count;

        case (state)
            S_IDLE: begin
                if (fs_c) begin
                    pending_nxt = req;
                    state_nxt   = S_SELECT;
                end
            end
            S_SELECT: begin
                if (!sel_found_c) begin
                    state_nxt = S_IDLE;
                end else begin
                    grant_nxt = N'(1) << sel_idx_c;
                    idx_nxt   = sel_idx_c;
                    timer_nxt = '0;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // done has priority, so a timeout never coincides with it
                if (done[cur_idx] || (timer == TW'(TIMEOUT - 1))) begin
                    grant_nxt            = '0;
                    pending_nxt[cur_idx] = 1'b0;
                    rr_nxt               = (cur_idx == IW'(N - 1)) ? '0 : cur_idx + IW'(1);
                    timeout_nxt          = !done[cur_idx];
                    state_nxt            = S_SELECT;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            default: begin
                grant_nxt = '0;
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_motion_scheduler.sv
// Self-checking bench for motion_scheduler: directed frames plus randomized
// frames, compared every cycle against a transaction-level reference model.
module tb_motion_scheduler;

    localparam int N  = 4;
    localparam int VB = 600;
    localparam int TO = 1024;

    logic          clock;
    logic          reset;
    logic [10:0]   display_row;
    logic [11:0]   display_col;
    logic [N-1:0]  req;
    logic [N-1:0]  done;
    logic [N-1:0]  grant;
    logic          frame_pulse;
    logic          busy;
    logic [15:0]   frame_count;
    logic          timeout;
    logic          overrun;

    motion_scheduler #(.N(N), .VBLANK_ROW(VB), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .display_row(display_row),
        .display_col(display_col), .req(req), .done(done), .grant(grant),
        .frame_pulse(frame_pulse), .busy(busy), .frame_count(frame_count),
        .timeout(timeout), .overrun(overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks;
    int failures;

    // Reference model: a frame is a set of objects still owed an update,
    // served one owner at a time with an idle cycle between owners.
    bit          m_vb;
    int          m_count;
    bit          m_active;
    int          m_owner;
    int          m_held;
    int          m_next;
    bit [N-1:0]  m_todo;
    bit          e_pulse, e_timeout, e_overrun;

    // Stimulus state: row/req levels and the object agents' done behaviour.
    logic [10:0]  row_v;
    logic [N-1:0] req_v;
    logic [N-1:0] done_force;
    logic [N-1:0] hold_mask;
    bit           noise_en, rand_delay, rand_hold, ag_hold;
    int           fix_delay, ag_cnt, ag_delay;

    // Observation logs.
    logic [N-1:0] glog[$];
    logic [N-1:0] prev_grant;
    int           cnt_pulse, cnt_timeout, cnt_overrun, cnt_g2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_vb = 0; m_count = 0; m_active = 0; m_owner = -1; m_held = 0;
        m_next = 0; m_todo = '0; e_pulse = 0; e_timeout = 0; e_overrun = 0;
    endtask

    task automatic m_step(input logic [10:0] row, input logic [N-1:0] rq, input logic [N-1:0] dn);
        bit fs;
        fs        = (row == 11'(VB)) && !m_vb;
        m_vb      = (row == 11'(VB));
        e_pulse   = fs;
        e_timeout = 0;
        e_overrun = fs && m_active;
        if (fs) m_count = (m_count + 1) % 65536;
        if (m_active) begin
            if (m_owner >= 0) begin
                if (dn[2'(m_owner)] || m_held == TO - 1) begin
                    e_timeout = !dn[2'(m_owner)];
                    m_todo[2'(m_owner)] = 0;
                    m_next  = (m_owner + 1) % N;
                    m_owner = -1;
                end else begin
                    m_held++;
                end
            end else begin
                int pick;
                pick = -1;
                for (int k = 0; k < N; k++)
                    if (pick < 0 && m_todo[2'((m_next + k) % N)]) pick = (m_next + k) % N;
                if (pick < 0) m_active = 0;
                else begin
                    m_owner = pick;
                    m_held  = 0;
                end
            end
        end else if (fs) begin
            m_todo   = rq;
            m_active = 1;
            m_owner  = -1;
        end
    endtask

    task automatic clear_logs();
        glog.delete();
        cnt_pulse = 0; cnt_timeout = 0; cnt_overrun = 0; cnt_g2 = 0;
    endtask

    function automatic logic [31:0] glog_packed();
        logic [31:0] p;
        p = '0;
        foreach (glog[i]) p = {p[27:0], glog[i]};
        return p;
    endfunction

    // One clock: drive inputs at the falling edge, step the model on the
    // rising edge, compare 1 time unit later.
    task automatic cycle();
        logic [N-1:0] dn;
        logic [N-1:0] eg;
        int           prev_owner;
        dn = noise_en ? (4'($urandom) & 4'($urandom) & 4'($urandom)) : '0;
        if (m_owner >= 0) begin
            dn[2'(m_owner)] = 1'b0;
            if (!ag_hold) begin
                if (ag_cnt == ag_delay) dn[2'(m_owner)] = 1'b1;
                ag_cnt++;
            end
        end
        dn          = dn | done_force;
        done_force  = '0;
        done        = dn;
        display_row = row_v;
        req         = req_v;
        display_col = 12'($urandom);
        prev_owner  = m_owner;
        @(posedge clock);
        if (!reset) m_reset();
        else m_step(display_row, req, done);
        if (m_owner >= 0 && m_owner != prev_owner) begin
            ag_cnt   = 1;
            ag_delay = rand_delay ? int'($urandom_range(1, 5)) : fix_delay;
            ag_hold  = hold_mask[2'(m_owner)] || (rand_hold && $urandom_range(0, 39) == 0);
        end
        #1;
        eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        chk("grant", 32'(grant), 32'(eg));
        chk("frame_pulse", 32'(frame_pulse), 32'(e_pulse));
        chk("busy", 32'(busy), 32'(m_active));
        chk("frame_count", 32'(frame_count), 32'(m_count));
        chk("timeout", 32'(timeout), 32'(e_timeout));
        chk("overrun", 32'(overrun), 32'(e_overrun));
        chk("onehot0", 32'($onehot0(grant)), 32'd1);
        if (grant != '0 && prev_grant == '0) glog.push_back(grant);
        if (grant == 4'b0010) cnt_g2++;
        if (frame_pulse) cnt_pulse++;
        if (timeout) cnt_timeout++;
        if (overrun) cnt_overrun++;
        prev_grant = grant;
        @(negedge clock);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        repeat (cycles) cycle();
        reset = 1'b1;
    endtask

    initial begin
        int base;
        int guard;
        checks = 0; failures = 0;
        row_v = '0; req_v = '0; done_force = '0; hold_mask = '0;
        noise_en = 0; rand_delay = 0; rand_hold = 0; ag_hold = 0;
        fix_delay = 3; ag_cnt = 0; ag_delay = 0; prev_grant = '0;
        reset = 1'b0; done = '0; req = '0; display_row = '0; display_col = '0;
        m_reset();
        clear_logs();
        @(negedge clock);

        // Reset then idle
        do_reset(5);
        repeat (3) cycle();
        chk("idle_count", 32'(frame_count), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_grant", 32'(grant), 32'd0);

        // Basic frame
        clear_logs();
        req_v = 4'b1011; row_v = 11'(VB);
        repeat (1000) cycle();
        row_v = '0;
        repeat (5) cycle();
        chk("basic_pulses", 32'(cnt_pulse), 32'd1);
        chk("basic_count", 32'(frame_count), 32'd1);
        chk("basic_order", glog_packed(), 32'h128);
        chk("basic_busy", 32'(busy), 32'd0);

        // Timeout frame, then a full rotation
        clear_logs();
        hold_mask = 4'b0010; req_v = 4'b1111; row_v = 11'(VB);
        repeat (1200) cycle();
        row_v = '0;
        repeat (5) cycle();
        chk("to_pulses", 32'(cnt_timeout), 32'd1);
        chk("to_g2_cycles", 32'(cnt_g2), 32'(TO));
        chk("to_order", glog_packed(), 32'h1248);
        clear_logs();
        hold_mask = '0; row_v = 11'(VB);
        repeat (100) cycle();
        row_v = '0;
        repeat (5) cycle();
        chk("rot_order", glog_packed(), 32'h1248);
        chk("rot_timeout", 32'(cnt_timeout), 32'd0);
        chk("rot_count", 32'(frame_count), 32'd3);

        // Overrun while a grant is held
        do_reset(2);
        clear_logs();
        req_v = 4'b0001; hold_mask = 4'b0001; row_v = 11'(VB);
        repeat (20) cycle();
        row_v = '0;
        repeat (20) cycle();
        row_v = 11'(VB);
        repeat (20) cycle();
        row_v = '0;
        repeat (3) cycle();
        chk("ovr_pulses", 32'(cnt_overrun), 32'd1);
        chk("ovr_count", 32'(frame_count), 32'd2);
        chk("ovr_grant_held", 32'(grant), 32'h1);
        hold_mask = '0; done_force = 4'b0001;
        repeat (5) cycle();
        chk("ovr_released", 32'(grant), 32'd0);
        chk("ovr_idle", 32'(busy), 32'd0);

        // Long blanking row: a single frame start
        clear_logs();
        base = int'(frame_count);
        req_v = 4'b1111; fix_delay = 2; row_v = 11'(VB);
        repeat (50000) cycle();
        row_v = '0;
        repeat (3) cycle();
        chk("long_pulses", 32'(cnt_pulse), 32'd1);
        chk("long_count", 32'(frame_count), 32'(base + 1));

        // Asynchronous reset mid-WAIT
        do_reset(2);
        clear_logs();
        req_v = 4'b0100; hold_mask = 4'b0100; row_v = 11'(VB);
        repeat (4) cycle();
        chk("arst_pre_grant", 32'(grant), 32'h4);
        #2 reset = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_count", 32'(frame_count), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        m_reset();
        hold_mask = '0; row_v = '0;
        repeat (2) cycle();
        reset = 1'b1;
        repeat (3) cycle();
        clear_logs();
        row_v = 11'(VB);
        repeat (10) cycle();
        row_v = '0;
        repeat (3) cycle();
        chk("arst_restart", glog_packed(), 32'h4);
        chk("arst_restart_count", 32'(frame_count), 32'd1);

        // Randomized frames with noise, random latencies and occasional timeouts
        noise_en = 1; rand_delay = 1; rand_hold = 1;
        for (int f = 0; f < 120; f++) begin
            req_v = 4'($urandom);
            row_v = 11'(VB);
            repeat ($urandom_range(1, 30)) cycle();
            repeat ($urandom_range(5, 60)) begin
                row_v = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(VB + 1, 2047))
                                                    : 11'($urandom_range(0, VB - 1));
                cycle();
            end
        end
        noise_en = 0; rand_hold = 0;
        row_v = '0;
        guard = 0;
        while (m_active && guard < 3000) begin
            cycle();
            guard++;
        end
        chk("drain_bound", 32'(m_active), 32'd0);
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/motion_scheduler.md
Name: motion_scheduler

Overview:
- Sequences per-frame position updates for up to N moving objects (ship, enemies, bullets) so updates happen only during vertical blanking.
- Replaces the free-running 2^20-cycle movement pulse with a frame-locked grant.
- Sits between the VGA timing generator (display_row/display_col) and the object blocks.
- Each object requests an update, receives a one-hot grant in round-robin order, performs its update, and signals done.

Parameters:
- N, 4, number of requesting objects (2..8).
- VBLANK_ROW, 600, display_row value marking the start of vertical blanking (VER_FIELD+1).
- TIMEOUT, 1024, maximum cycles a grant is held waiting for done.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- display_row  input  11  current VGA row.
- display_col  input  12  current VGA column (unused except for lint; reserved).
- req  input  N  per-object update request, level, sampled at frame start.
- done  input  N  per-object completion, one-cycle pulse; only the bit of the granted object is honoured.
- grant  output  N  one-hot update grant, held until done or timeout.
- frame_pulse  output  1  one-cycle pulse at each detected frame start.
- busy  output  1  high whenever state is not IDLE.
- frame_count  output  16  frames detected since reset, wraps.
- timeout  output  1  one-cycle pulse when a grant is revoked by timeout.
- overrun  output  1  one-cycle pulse when a frame start arrives while busy.

Behaviour:
- Reset (reset=0, asynchronous): all of the following clear.
  - grant=0, frame_pulse=0, busy=0, frame_count=0, timeout=0, overrun=0.
  - pending=0, rr_ptr=0, state=IDLE, timer=0, vb_q=0.
- vb_q is the registered value of (display_row==VBLANK_ROW).
- Frame start is the cycle when (display_row==VBLANK_ROW) && !vb_q; one frame start per VBLANK_ROW entry regardless of how many cycles the row lasts.
- On every frame start:
  - frame_pulse=1 next cycle.
  - frame_count+1 (mod 2^16).
- The frame start is accepted only if state is IDLE:
  - pending<=req.
  - state->SELECT.
- Frame start while not IDLE:
  - overrun=1 for one cycle.
  - req not sampled; the current frame's remaining work continues.
- States:
  - IDLE: wait for an accepted frame start.
  - SELECT (one cycle):
    - if pending==0, go to IDLE.
    - else choose the first set pending bit searching upward from rr_ptr, wrapping mod N.
    - grant<=onehot(i), timer<=0, go to WAIT.
  - WAIT:
    - if done[i]: grant<=0, pending[i]<=0, rr_ptr<=(i+1) mod N, go to SELECT.
    - else if timer==TIMEOUT-1: same actions as done, plus timeout=1 for one cycle.
    - else timer+1.
    - done bits of non-granted objects are ignored.
- Latency:
  - Frame start on edge k: frame_pulse and state SELECT visible after edge k.
  - First grant visible after edge k+1.
  - Grant drops on the edge after done is sampled.
  - Next grant appears one cycle later, so there is a one-cycle gap with grant=0 between consecutive grants.
- grant is never multi-hot; at most one bit is set at any cycle.
- req changes after the frame start do not affect the current frame.
- A req bit low at frame start is skipped for that frame.
- done and timeout on the same cycle is impossible by construction (done has priority); timeout does not pulse in that case.
- busy = (state != IDLE), registered with the state.
- Reset asserted mid-WAIT clears grant immediately (asynchronous); no done is expected afterwards.

Test Plan:
1. Reset then idle: hold reset=0 for 5 cycles, release, display_row=0.
   -> grant=0, busy=0, frame_count=0, all pulses 0.
2. Basic frame (N=4): req=4'b1011, display_row steps to 600 for 1000 cycles; each object pulses done 3 cycles after its grant.
   -> frame_pulse once, frame_count=1.
   -> grants in order 0001, 0010, 1000, each separated by a zero cycle; busy then falls.
3. Round-robin rotation: after scenario 2 (rr_ptr=0 after serving 3), object 1 times out in a frame with req=1111, and the next frame has req=1111.
   -> in the timeout frame, timeout pulses after exactly 1024 cycles of grant 0010, then grant 0100.
   -> the next frame starts from rr_ptr, with no skipped or duplicate grants.
4. Overrun: req=0001, done withheld, second frame start arrives (row leaves 600 and returns) before timeout.
   -> overrun=1 one cycle, frame_count=2, grant 0001 still held until done.
5. Row held at VBLANK_ROW for 50000 cycles.
   -> exactly one frame start; frame_count increments by 1.
6. Asynchronous reset during WAIT with grant=0100, reset pulsed mid-cycle.
   -> grant=0 before the next clock edge; frame_count=0, state IDLE.
   -> a frame start after release begins normally.
